// File: rtl/register_file_param.sv
// Parametrised CPU register file with a hardware program counter and a bounded,
// downward-growing stack pointer. Reads are registered with one cycle of latency.
module register_file_param #(
    parameter int unsigned      WIDTH       = 16,
    parameter int unsigned      NUM_REGS    = 8,
    parameter int unsigned      P_INDEX     = 3,
    parameter int unsigned      S_INDEX     = 4,
    parameter logic [WIDTH-1:0] PC_RESET    = '0,
    parameter logic [WIDTH-1:0] STACK_BASE  = 16'hFF00,
    parameter logic [WIDTH-1:0] STACK_LIMIT = 16'hFE00,
    localparam int unsigned     SW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    input  logic             write_en,
    input  logic [SW-1:0]    write_sel,
    input  logic             read_en,
    input  logic [SW-1:0]    read_sel,
    input  logic             pc_inc,
    input  logic             sp_push,
    input  logic             sp_pop,
    output logic [WIDTH-1:0] S_out,
    output logic [WIDTH-1:0] P_out,
    output logic             stack_overflow,
    output logic             stack_underflow
);

    // Parameter sanity: the dedicated P and S slots must be distinct and exist.
    if (P_INDEX == S_INDEX) begin : gen_index_collision
        $error("register_file_param: P_INDEX and S_INDEX must differ");
    end
    if (P_INDEX >= NUM_REGS || S_INDEX >= NUM_REGS) begin : gen_index_range
        $error("register_file_param: P_INDEX/S_INDEX must be below NUM_REGS");
    end
    if (STACK_LIMIT > STACK_BASE) begin : gen_stack_bounds
        $error("register_file_param: STACK_LIMIT must not exceed STACK_BASE");
    end

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];
    logic [WIDTH-1:0] bus_out_q, bus_out_d;
    logic             bus_oe_q;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             read_valid;
    logic             write_valid;
    logic             push_only;
    logic             pop_only;
    logic [WIDTH-1:0] sp;
    logic [WIDTH-1:0] pc;

    assign sp = regs_q[S_INDEX];
    assign pc = regs_q[P_INDEX];

    // Guards only matter when NUM_REGS is not a power of two.
    assign read_valid  = 32'(read_sel) < NUM_REGS;
    assign write_valid = 32'(write_sel) < NUM_REGS;

    // A simultaneous push and pop cancels out entirely.
    assign push_only = sp_push & ~sp_pop;
    assign pop_only  = sp_pop & ~sp_push;

    always_comb begin
        regs_d = regs_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;

        if (pc_inc) begin
            regs_d[P_INDEX] = pc + {{(WIDTH-1){1'b0}}, 1'b1};
        end

        if (push_only) begin
            if (sp == STACK_LIMIT) begin
                ovf_d = 1'b1;
            end else begin
                regs_d[S_INDEX] = sp - {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end else if (pop_only) begin
            if (sp == STACK_BASE) begin
                unf_d = 1'b1;
            end else begin
                regs_d[S_INDEX] = sp + {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end

        // Bus writes take priority over PC/SP updates; writing S restarts flag tracking.
        if (write_en && write_valid) begin
            regs_d[write_sel] = bus_in;
            if (32'(write_sel) == S_INDEX) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
        end
    end

    always_comb begin
        bus_out_d = bus_out_q;
        if (read_en) begin
            bus_out_d = read_valid ? regs_q[read_sel] : '0;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i == P_INDEX) begin
                    regs_q[i] <= PC_RESET;
                end else if (i == S_INDEX) begin
                    regs_q[i] <= STACK_BASE;
                end else begin
                    regs_q[i] <= '0;
                end
            end
            bus_out_q <= '0;
            bus_oe_q  <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            bus_out_q <= bus_out_d;
            bus_oe_q  <= read_en;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign bus_out         = bus_out_q;
    assign bus_oe          = bus_oe_q;
    assign P_out           = pc;
    assign S_out           = sp;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule
